// File: rtl/play_scheduler.sv
// Track/volume scheduler for a VS1003B mp3 player: arbitrates Bluetooth and
// button commands round-robin, services end-of-track auto-advance, and times restarts.
module play_scheduler #(
    parameter int         NUM_SONGS   = 5,
    parameter logic [7:0] VOL_INIT    = 8'h20,
    parameter logic [7:0] VOL_STEP    = 8'h10,
    parameter logic [7:0] VOL_MUTE    = 8'hF0,
    parameter int         RESTART_LEN = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        BT_VALID,
    input  logic [3:0]  BT_CMD,
    output logic        BT_READY,
    input  logic        BTN_VALID,
    input  logic [3:0]  BTN_CMD,
    output logic        BTN_READY,
    input  logic        TRACK_END,
    output logic [2:0]  CURRENT,
    output logic [15:0] VOL,
    output logic        PAUSE,
    output logic        MP3_RST,
    output logic        BUSY
);

    localparam logic [0:0] S_IDLE    = 1'b0;
    localparam logic [0:0] S_RESTART = 1'b1;

    localparam logic [2:0] CMD_NOP   = 3'h0;
    localparam logic [2:0] CMD_PLAY  = 3'h1;
    localparam logic [2:0] CMD_NEXT  = 3'h2;
    localparam logic [2:0] CMD_PREV  = 3'h3;
    localparam logic [2:0] CMD_VUP   = 3'h4;
    localparam logic [2:0] CMD_VDN   = 3'h5;

    localparam logic [2:0] LAST_TRACK = 3'(NUM_SONGS - 1);
    localparam logic [3:0] SONG_CNT   = 4'(NUM_SONGS);
    localparam logic [7:0] LEN_M1     = 8'(RESTART_LEN - 1);

    logic [0:0] r_state;
    logic [7:0] r_cnt;
    logic       r_pending;
    logic       r_last_bt;
    logic [2:0] r_current;
    logic [7:0] r_vol;
    logic       r_pause;

    logic       w_idle;
    logic       w_arb;
    logic       w_auto;
    logic       w_gnt_bt;
    logic       w_gnt_btn;
    logic       w_accept;
    logic [3:0] w_cmd;
    logic       w_te;
    logic [2:0] w_cur_inc;
    logic [2:0] w_cur_dec;
    logic [7:0] w_vol_up;
    logic [8:0] w_vol_sum;
    logic [7:0] w_vol_dn;
    logic [2:0] w_nxt_current;
    logic [7:0] w_nxt_vol;
    logic       w_nxt_pause;
    logic       w_restart;

    assign w_idle = (r_state == S_IDLE);
    assign w_auto = w_idle & r_pending;
    assign w_arb  = w_idle & ~r_pending;

    // Round-robin: on contention the requester not served last wins.
    assign w_gnt_bt  = w_arb & BT_VALID  & (~BTN_VALID | ~r_last_bt);
    assign w_gnt_btn = w_arb & BTN_VALID & (~BT_VALID  |  r_last_bt);
    assign w_accept  = w_gnt_bt | w_gnt_btn;
    assign w_cmd     = w_gnt_bt ? BT_CMD : BTN_CMD;

    assign BT_READY  = w_gnt_bt;
    assign BTN_READY = w_gnt_btn;

    // End-of-track pulses are dropped while paused.
    assign w_te = TRACK_END & ~r_pause;

    assign w_cur_inc = (r_current == LAST_TRACK) ? 3'd0 : r_current + 3'd1;
    assign w_cur_dec = (r_current == 3'd0) ? LAST_TRACK : r_current - 3'd1;

    assign w_vol_up  = (r_vol < VOL_STEP) ? 8'h00 : r_vol - VOL_STEP;
    assign w_vol_sum = {1'b0, r_vol} + {1'b0, VOL_STEP};
    assign w_vol_dn  = (w_vol_sum > {1'b0, VOL_MUTE}) ? VOL_MUTE : w_vol_sum[7:0];

    always_comb begin
        w_nxt_current = r_current;
        w_nxt_vol     = r_vol;
        w_nxt_pause   = r_pause;
        w_restart     = 1'b0;
        if (w_auto) begin
            w_nxt_current = w_cur_inc;
            w_nxt_pause   = 1'b0;
            w_restart     = 1'b1;
        end else if (w_accept) begin
            if (w_cmd[3]) begin
                // Out-of-range selects are consumed without effect.
                if ({1'b0, w_cmd[2:0]} < SONG_CNT) begin
                    w_nxt_current = w_cmd[2:0];
                    w_nxt_pause   = 1'b0;
                    w_restart     = 1'b1;
                end
            end else begin
                case (w_cmd[2:0])
                    CMD_PLAY: w_nxt_pause = ~r_pause;
                    CMD_NEXT: begin
                        w_nxt_current = w_cur_inc;
                        w_nxt_pause   = 1'b0;
                        w_restart     = 1'b1;
                    end
                    CMD_PREV: begin
                        w_nxt_current = w_cur_dec;
                        w_nxt_pause   = 1'b0;
                        w_restart     = 1'b1;
                    end
                    CMD_VUP:  w_nxt_vol = w_vol_up;
                    CMD_VDN:  w_nxt_vol = w_vol_dn;
                    CMD_NOP:  ;
                    default:  ;
                endcase
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_current <= 3'd0;
            r_vol     <= VOL_INIT;
            r_pause   <= 1'b0;
            r_last_bt <= 1'b0;
        end else begin
            r_current <= w_nxt_current;
            r_vol     <= w_nxt_vol;
            r_pause   <= w_nxt_pause;
            if (w_gnt_bt)
                r_last_bt <= 1'b1;
            else if (w_gnt_btn)
                r_last_bt <= 1'b0;
        end
    end

    // Pending auto-next: collapses repeated pulses, cleared when serviced.
    always_ff @(posedge CLK) begin
        if (RST)
            r_pending <= 1'b0;
        else
            r_pending <= (r_pending & ~w_auto) | w_te;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= S_IDLE;
            r_cnt   <= 8'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_restart) begin
                        r_state <= S_RESTART;
                        r_cnt   <= LEN_M1;
                    end
                end
                S_RESTART: begin
                    if (r_cnt == 8'd0)
                        r_state <= S_IDLE;
                    else
                        r_cnt <= r_cnt - 8'd1;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign CURRENT = r_current;
    assign VOL     = {r_vol, r_vol};
    assign PAUSE   = r_pause;
    assign BUSY    = (r_state == S_RESTART);
    assign MP3_RST = (r_state == S_RESTART);

endmodule

// File: tb/tb_play_scheduler.sv
// Scoreboard bench for play_scheduler: directed commands push expected results,
// a negedge monitor pops and compares on each handshake or auto-advance.
module tb_play_scheduler;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        BT_VALID = 1'b0;
    logic [3:0]  BT_CMD = 4'h0;
    logic        BT_READY;
    logic        BTN_VALID = 1'b0;
    logic [3:0]  BTN_CMD = 4'h0;
    logic        BTN_READY;
    logic        TRACK_END = 1'b0;
    logic [2:0]  CURRENT;
    logic [15:0] VOL;
    logic        PAUSE;
    logic        MP3_RST;
    logic        BUSY;

    localparam int WHO_BT = 0, WHO_BTN = 1, WHO_AUTO = 2;

    typedef struct {
        int          who;
        logic [2:0]  cur;
        logic [15:0] vol;
        logic        pause;
        logic        rst;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    play_scheduler #(
        .NUM_SONGS(5), .VOL_INIT(8'h20), .VOL_STEP(8'h10),
        .VOL_MUTE(8'hF0), .RESTART_LEN(4)
    ) dut (
        .CLK(CLK), .RST(RST),
        .BT_VALID(BT_VALID), .BT_CMD(BT_CMD), .BT_READY(BT_READY),
        .BTN_VALID(BTN_VALID), .BTN_CMD(BTN_CMD), .BTN_READY(BTN_READY),
        .TRACK_END(TRACK_END), .CURRENT(CURRENT), .VOL(VOL), .PAUSE(PAUSE),
        .MP3_RST(MP3_RST), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, req);
        end
    endtask

    function automatic exp_t mk(input int who, input logic [2:0] cur,
                                input logic [15:0] vol, input logic pause, input logic rst);
        exp_t e;
        e.who = who; e.cur = cur; e.vol = vol; e.pause = pause; e.rst = rst;
        return e;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic do_reset;
        RST = 1'b1;
        tick(2);
        RST = 1'b0;
    endtask

    // Call at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic issue(input bit btn, input logic [3:0] cmd, input exp_t e);
        bit got;
        sb.push_back(e);
        if (btn) begin BTN_VALID = 1'b1; BTN_CMD = cmd; end
        else     begin BT_VALID  = 1'b1; BT_CMD  = cmd; end
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge CLK);
            got = btn ? BTN_READY : BT_READY;
        end
        if (!got) begin
            total++; bad++;
            $display("FAIL handshake_timeout: got no READY want READY (cmd %0h)", cmd);
        end
        @(posedge CLK); #1;
        if (btn) BTN_VALID = 1'b0; else BT_VALID = 1'b0;
    endtask

    // Monitor: compares outputs the cycle after each accept or auto-advance.
    initial begin : monitor
        bit   prev_hs, prev_busy, hs, evt;
        int   prev_who, run, who;
        exp_t e;
        prev_hs = 0; prev_busy = 0; prev_who = 0; run = 0;
        forever begin
            @(negedge CLK);
            if (RST) begin
                prev_hs = 0; prev_busy = 0; run = 0;
            end else begin
                if (MP3_RST) run++;
                else if (run != 0) begin
                    chk("mp3_rst_len", run, 4);
                    run = 0;
                end
                if (BUSY) chk("ready_in_restart", {BT_READY, BTN_READY}, 2'b00);
                chk("single_grant", BT_READY & BTN_READY, 1'b0);
                evt = 0; who = 0;
                if (prev_hs) begin evt = 1; who = prev_who; end
                else if (BUSY && !prev_busy) begin evt = 1; who = WHO_AUTO; end
                if (evt) begin
                    if (sb.size() == 0) begin
                        total++; bad++;
                        $display("FAIL unexpected_event: got who=%0d want no event", who);
                    end else begin
                        e = sb.pop_front();
                        chk("who", who, e.who);
                        chk("current", CURRENT, e.cur);
                        chk("vol", VOL, e.vol);
                        chk("pause", PAUSE, e.pause);
                        chk("restart", BUSY, e.rst);
                    end
                end
                hs = (BT_VALID & BT_READY) | (BTN_VALID & BTN_READY);
                prev_who  = (BT_VALID & BT_READY) ? WHO_BT : WHO_BTN;
                prev_hs   = hs;
                prev_busy = BUSY;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        do_reset();
        @(negedge CLK);
        chk("rst_current", CURRENT, 3'd0);
        chk("rst_vol", VOL, 16'h2020);
        chk("rst_pause", PAUSE, 1'b0);
        chk("rst_mp3", MP3_RST, 1'b0);
        chk("rst_busy", BUSY, 1'b0);
        chk("rst_ready", {BT_READY, BTN_READY}, 2'b00);
        tick(1);

        // NEXT after reset, then a NOP held through the restart window
        issue(0, 4'h2, mk(WHO_BT, 3'd1, 16'h2020, 0, 1));
        issue(0, 4'h0, mk(WHO_BT, 3'd1, 16'h2020, 0, 0));

        // wrap-around, out-of-range select, same-track select, auto-next in restart
        issue(1, 4'hC, mk(WHO_BTN, 3'd4, 16'h2020, 0, 1));
        issue(0, 4'h2, mk(WHO_BT,  3'd0, 16'h2020, 0, 1));
        issue(1, 4'h3, mk(WHO_BTN, 3'd4, 16'h2020, 0, 1));
        issue(0, 4'hE, mk(WHO_BT,  3'd4, 16'h2020, 0, 0));
        issue(1, 4'hC, mk(WHO_BTN, 3'd4, 16'h2020, 0, 1));
        sb.push_back(mk(WHO_AUTO, 3'd0, 16'h2020, 0, 1));
        TRACK_END = 1'b1; tick(1); TRACK_END = 1'b0;
        tick(14);

        // contention: both valid with VOL_UP
        do_reset();
        sb.push_back(mk(WHO_BT,  3'd0, 16'h1010, 0, 0));
        sb.push_back(mk(WHO_BTN, 3'd0, 16'h0000, 0, 0));
        sb.push_back(mk(WHO_BT,  3'd0, 16'h0000, 0, 0));
        BT_VALID = 1'b1; BT_CMD = 4'h4; BTN_VALID = 1'b1; BTN_CMD = 4'h4;
        tick(3);
        BT_VALID = 1'b0; BTN_VALID = 1'b0;
        tick(2);

        // volume down saturation, pause, discarded track end
        for (int k = 1; k <= 20; k++) begin
            logic [7:0] b;
            b = (k >= 15) ? 8'hF0 : 8'(k * 16);
            issue(1, 4'h5, mk(WHO_BTN, 3'd0, {b, b}, 0, 0));
        end
        issue(1, 4'h1, mk(WHO_BTN, 3'd0, 16'hF0F0, 1, 0));
        TRACK_END = 1'b1; tick(1); TRACK_END = 1'b0;
        tick(6);
        chk("paused_current", CURRENT, 3'd0);
        chk("paused_busy", BUSY, 1'b0);
        issue(1, 4'h1, mk(WHO_BTN, 3'd0, 16'hF0F0, 0, 0));
        tick(4);

        // double track end during restart, ahead of a waiting button command
        issue(0, 4'h2, mk(WHO_BT, 3'd1, 16'hF0F0, 0, 1));
        sb.push_back(mk(WHO_AUTO, 3'd2, 16'hF0F0, 0, 1));
        TRACK_END = 1'b1; tick(1); TRACK_END = 1'b0; tick(1);
        TRACK_END = 1'b1; tick(1); TRACK_END = 1'b0;
        issue(1, 4'h4, mk(WHO_BTN, 3'd2, 16'hE0E0, 0, 0));
        tick(10);
        chk("single_advance", CURRENT, 3'd2);

        // reset in the middle of a restart
        issue(0, 4'h2, mk(WHO_BT, 3'd3, 16'hE0E0, 0, 1));
        tick(1);
        RST = 1'b1;
        tick(1);
        RST = 1'b0;
        @(negedge CLK);
        chk("midrst_current", CURRENT, 3'd0);
        chk("midrst_mp3", MP3_RST, 1'b0);
        chk("midrst_vol", VOL, 16'h2020);
        chk("midrst_busy", BUSY, 1'b0);
        chk("midrst_pause", PAUSE, 1'b0);
        tick(3);

        chk("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/play_scheduler.md
PLAY_SCHEDULER -- requirements
Module: play_scheduler

Interface
REQ-001 Parameter NUM_SONGS, default 5: number of valid tracks, indices 0..NUM_SONGS-1, range 1..8.
REQ-002 Parameter VOL_INIT, default 8'h20: per-channel attenuation byte loaded at reset.
REQ-003 Parameter VOL_STEP, default 8'h10: attenuation change per volume command.
REQ-004 Parameter VOL_MUTE, default 8'hF0: maximum attenuation byte (quietest).
REQ-005 Parameter RESTART_LEN, default 4: number of cycles MP3_RST stays high after a track change, range 1..255.
REQ-006 CLK  in  1  system clock; the only clock.
REQ-007 RST  in  1  synchronous, active-high reset.
REQ-008 BT_VALID  in  1  Bluetooth requester has a command.
REQ-009 BT_CMD  in  4  Bluetooth command code.
REQ-010 BT_READY  out  1  Bluetooth command accepted when BT_VALID & BT_READY.
REQ-011 BTN_VALID  in  1  button requester has a command.
REQ-012 BTN_CMD  in  4  button command code.
REQ-013 BTN_READY  out  1  button command accepted when BTN_VALID & BTN_READY.
REQ-014 TRACK_END  in  1  one-cycle pulse from the mp3 player at end of track.
REQ-015 CURRENT  out  3  selected track index.
REQ-016 VOL  out  16  VS1003B volume word; both bytes always equal.
REQ-017 PAUSE  out  1  playback paused.
REQ-018 MP3_RST  out  1  restart request to the mp3 player and time counter.
REQ-019 BUSY  out  1  high while in RESTART state.

Function
REQ-020 Command codes SHALL be: 4'h0 NOP, 4'h1 PLAY/PAUSE toggle, 4'h2 NEXT, 4'h3 PREV, 4'h4 VOL_UP, 4'h5 VOL_DOWN, 4'b1iii SELECT track iii; all other codes are treated as NOP.
REQ-021 FSM SHALL have two states, IDLE and RESTART; BT_READY and BTN_READY are low in RESTART.
REQ-022 In IDLE, a pending auto-next (TRACK_END seen) SHALL take priority; both READYs are low during the cycle it is serviced.
REQ-023 Otherwise the arbiter SHALL grant by round-robin: a single valid requester gets READY; if both are valid, the requester not served last gets READY. After reset, "last served" is BTN.
REQ-024 Only the granted requester's READY SHALL be high; READY depends combinationally on VALID, state and last-served.
REQ-025 An accepted command SHALL update CURRENT, VOL and PAUSE on the next clock edge, giving 1-cycle latency.
REQ-026 NEXT SHALL set CURRENT to (CURRENT+1) and wrap from NUM_SONGS-1 to 0; PREV SHALL wrap from 0 to NUM_SONGS-1.
REQ-027 SELECT with index >= NUM_SONGS SHALL be accepted and ignored, with no state change and no restart.
REQ-028 NEXT, PREV, valid SELECT and auto-next SHALL clear PAUSE, enter RESTART, and drive MP3_RST high for exactly RESTART_LEN cycles, starting the cycle after acceptance; the FSM then returns to IDLE.
REQ-029 SELECT of the index already in CURRENT SHALL still restart the track.
REQ-030 VOL_UP SHALL subtract VOL_STEP from the byte, saturating at 8'h00; VOL_DOWN SHALL add VOL_STEP, saturating at VOL_MUTE. Neither SHALL cause a restart.
REQ-031 PLAY/PAUSE SHALL toggle PAUSE with no restart; NOP SHALL be accepted with no effect.
REQ-032 A TRACK_END arriving in RESTART, or while another command is being accepted, SHALL be latched as pending; multiple pulses collapse into one.
REQ-033 A TRACK_END arriving while PAUSE=1 SHALL be discarded.

Reset
REQ-034 On RST=1 at a clock edge, the block SHALL set: CURRENT=0, VOL={VOL_INIT,VOL_INIT}, PAUSE=0, MP3_RST=0, BUSY=0, state IDLE, pending auto-next cleared, last-served BTN.
REQ-035 RST SHALL override any operation in progress, including mid-RESTART; MP3_RST SHALL drop on the cycle after reset is sampled.

Verification
REQ-036 After reset, pulse BT_VALID with BT_CMD=2 -> CURRENT=1 next cycle, MP3_RST high for 4 cycles, BUSY high, READYs low throughout, then IDLE.
REQ-037 With CURRENT=4, NEXT -> CURRENT=0; then PREV -> CURRENT=4; then BT_CMD=4'b1110 -> accepted, CURRENT stays 4, no MP3_RST.
REQ-038 Both requesters valid continuously with VOL_UP -> grants alternate BT, BTN, BT, and so on; VOL goes 16'h1010, 16'h0000, 16'h0000 (saturated).
REQ-039 Issue VOL_DOWN 20 times -> VOL saturates at 16'hF0F0; PLAY/PAUSE -> PAUSE=1; then TRACK_END -> no change.
REQ-040 Pulse TRACK_END twice during RESTART -> exactly one further advance, serviced ahead of a simultaneously valid BTN command.
REQ-041 Assert RST on the 2nd RESTART cycle -> next cycle CURRENT=0, MP3_RST=0, VOL=16'h2020, BUSY=0.
